// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage.
package pipe_pkg;

  // Instruction value shown while the stage holds a bubble.
  localparam int unsigned NOP_IR_DEFAULT = 0;

  // Occupancy as seen from the two valid bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BOTH  = 2'd2
  } pipe_state_e;

  // Packed width of one stored {PC, IR, ctrl} entry.
  function automatic int unsigned payload_width(input int unsigned pc_w,
                                                input int unsigned ir_w,
                                                input int unsigned ctrl_w);
    return pc_w + ir_w + ctrl_w;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot: a valid bit plus a payload register.
module pipe_entry #(
  parameter int unsigned W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Valid bit: reset/clear win, then load sets, then drop clears.
  always_ff @(posedge clk) begin
    if (reset || clr)
      valid <= 1'b0;
    else if (load)
      valid <= 1'b1;
    else if (drop)
      valid <= 1'b0;
  end

  // Payload only changes on load; it is never cleared.
  always_ff @(posedge clk) begin
    if (load)
      q <= d;
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline latch between processor stages: valid/ready handshake,
// two-entry skid buffer, flush with bubble injection, stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      PC_W   = 32,
  parameter int unsigned      IR_W   = 32,
  parameter int unsigned      CTRL_W = 8,
  parameter logic [IR_W-1:0]  NOP_IR = IR_W'(NOP_IR_DEFAULT),
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_PC,
  input  logic [IR_W-1:0]   in_IR,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_PC,
  output logic [IR_W-1:0]   out_IR,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PAY_W = payload_width(PC_W, IR_W, CTRL_W);

  logic             main_valid, skid_valid;
  logic [PAY_W-1:0] main_q, skid_q, main_d, in_pay;
  logic             push, pop;
  logic             main_load, skid_load;
  pipe_state_e      state;

  assign in_pay   = {in_PC, in_IR, in_ctrl};
  assign in_ready = !skid_valid && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = main_valid && out_ready;

  // MAIN refills from SKID when it holds data, otherwise from the input;
  // push is already blocked in BOTH, so the two sources never collide.
  assign main_load = (skid_valid && pop) || (push && (!main_valid || pop));
  assign main_d    = skid_valid ? skid_q : in_pay;
  assign skid_load = push && main_valid && !pop;

  pipe_entry #(.W(PAY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .load  (main_load),
    .drop  (pop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  pipe_entry #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .load  (skid_load),
    .drop  (pop),
    .d     (in_pay),
    .valid (skid_valid),
    .q     (skid_q)
  );

  // Bubble mux on the MAIN valid bit.
  always_comb begin
    out_valid = main_valid;
    out_PC    = '0;
    out_IR    = NOP_IR;
    out_ctrl  = '0;
    if (main_valid)
      {out_PC, out_IR, out_ctrl} = main_q;
  end

  // Saturating count of back-pressured cycles.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Occupancy decode for debug and assertions.
  always_comb begin
    state = ST_EMPTY;
    if (skid_valid)
      state = ST_BOTH;
    else if (main_valid)
      state = ST_FULL;
  end

  a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
    skid_valid |-> main_valid);
  a_both_not_ready: assert property (@(posedge clk) disable iff (reset)
    (state == ST_BOTH) |-> !in_ready);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic against a queue-based model.
module tb_pipe_stage_elastic;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          SAT = 15;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_PC, in_IR, out_PC, out_IR;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [71:0] mq[$];
  int          mcnt = 0;
  bit          known = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .PC_W   (32),
    .IR_W   (32),
    .CTRL_W (8),
    .NOP_IR (NOP),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_PC     (in_PC),
    .in_IR     (in_IR),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_PC    (out_PC),
    .out_IR    (out_IR),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs mid-cycle, compare against the model, then
  // advance the model by the transfer rules and wait for the edge.
  task automatic cycle(input bit iv, input logic [31:0] pc, input logic [31:0] ir,
                       input logic [7:0] ct, input bit fl, input bit ordy, input bit rst);
    int sz;
    bit acc;
    logic [71:0] head;
    @(negedge clk);
    in_valid = iv; in_PC = pc; in_IR = ir; in_ctrl = ct;
    flush = fl; out_ready = ordy; reset = rst;
    #1;
    if (known) begin
      head = (mq.size() > 0) ? mq[0] : {32'h0, NOP, 8'h0};
      check("in_ready",  64'(in_ready),  64'((mq.size() < 2) && !fl));
      check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("out_PC",    64'(out_PC),    64'(head[71:40]));
      check("out_IR",    64'(out_IR),    64'(head[39:8]));
      check("out_ctrl",  64'(out_ctrl),  64'(head[7:0]));
      check("stall_cnt", 64'(stall_cnt), 64'(mcnt));
    end
    if (rst) begin
      mq.delete();
      mcnt  = 0;
      known = 1;
    end else if (known) begin
      sz = mq.size();
      if (sz > 0 && !ordy && mcnt < SAT) mcnt++;
      if (fl) mq.delete();
      else begin
        acc = iv && (sz < 2);
        if (sz > 0 && ordy) void'(mq.pop_front());
        if (acc) mq.push_back({pc, ir, ct});
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    in_valid = 0; in_PC = 0; in_IR = 0; in_ctrl = 0;
    flush = 0; out_ready = 0; reset = 1;
    do_reset();

    // Streaming at full rate.
    cycle(1, 32'h10, 32'hA, 8'h1, 0, 1, 0); #2 check("stream_pc0", 64'(out_PC), 64'h10);
    cycle(1, 32'h14, 32'hB, 8'h2, 0, 1, 0); #2 check("stream_pc1", 64'(out_PC), 64'h14);
    cycle(1, 32'h18, 32'hC, 8'h3, 0, 1, 0); #2 check("stream_pc2", 64'(out_PC), 64'h18);
    check("stream_ir2", 64'(out_IR), 64'hC);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("stream_stall", 64'(stall_cnt), 64'h0);

    // Back-pressure into the skid entry, then drain.
    do_reset();
    cycle(1, 32'h10, 32'hA, 8'h0, 0, 0, 0);
    cycle(1, 32'h14, 32'hB, 8'h0, 0, 0, 0);
    #2 check("bp_ready_low", 64'(in_ready), 64'h0);
    check("bp_main", 64'(out_PC), 64'h10);
    cycle(1, 32'h18, 32'hC, 8'h0, 0, 0, 0);
    cycle(1, 32'h18, 32'hC, 8'h0, 0, 1, 0); #2 check("bp_out1", 64'(out_PC), 64'h14);
    cycle(1, 32'h18, 32'hC, 8'h0, 0, 1, 0); #2 check("bp_out2", 64'(out_PC), 64'h18);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("bp_stall", 64'(stall_cnt), 64'h2);

    // Flush while BOTH with a competing push.
    do_reset();
    cycle(1, 32'h30, 32'h1, 8'h0, 0, 0, 0);
    cycle(1, 32'h34, 32'h2, 8'h0, 0, 0, 0);
    cycle(1, 32'h38, 32'h3, 8'h0, 1, 0, 0);
    #2 check("fl_valid", 64'(out_valid), 64'h0);
    check("fl_ir", 64'(out_IR), 64'(NOP));
    check("fl_pc", 64'(out_PC), 64'h0);
    cycle(1, 32'h3C, 32'h4, 8'h5, 0, 0, 0); #2 check("fl_next", 64'(out_PC), 64'h3C);

    // Simultaneous push and pop while FULL.
    do_reset();
    cycle(1, 32'h20, 32'h7, 8'h0, 0, 0, 0);
    cycle(1, 32'h24, 32'h8, 8'h0, 0, 1, 0);
    #2 check("pp_main", 64'(out_PC), 64'h24);
    check("pp_skid_empty", 64'(in_ready), 64'h1);

    // Counter saturation, then reset.
    do_reset();
    cycle(1, 32'h50, 32'h9, 8'h0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    #2 check("sat_cnt", 64'(stall_cnt), 64'(SAT));
    do_reset();
    #2 check("rst_cnt", 64'(stall_cnt), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h1);

    // Reset dominates flush, push and pop together.
    cycle(1, 32'h40, 32'hD, 8'h0, 0, 0, 0);
    cycle(1, 32'h44, 32'hE, 8'h0, 1, 1, 1);
    #2 check("rp_valid", 64'(out_valid), 64'h0);
    check("rp_cnt", 64'(stall_cnt), 64'h0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      cycle(bit'($urandom_range(0, 3) != 0), $urandom, $urandom, 8'($urandom),
            bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 9) < 6),
            bit'($urandom_range(0, 79) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
